filter_stream_engine: RTL and testbench

FILTER_STREAM_ENGINE -- requirements
Module: filter_stream_engine

---
 rtl/filter_stream_engine.sv | 183 ++++++++++++++++++
 tb/tb_filter_stream_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_stream_engine.sv
// Streams one filter group of {value,index} weight words from the weight SRAM to a PE.
// Latency: first SRAM read 2 cycles after the request is seen in IDLE, 1 word/cycle sustained.
// Backpressure: a 2-entry skip FIFO absorbs out_ready stalls; reads are throttled so it never overflows.
// Optional feature macro: FILTER_STREAM_ZERO_SKIP_EN (drop words whose value field is zero).
module filter_stream_engine #(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 8,
    parameter int ADDR_W  = 12,
    parameter int LAYER_W = 2,
    parameter int K_W     = 6,
    parameter int CNT_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_filter_valid,
    input  logic [K_W-1:0]           req_filter_k,
    input  logic [LAYER_W-1:0]       req_conv_layer,
    input  logic [4*ADDR_W-1:0]      layer_base_addr,
    input  logic [4*CNT_W-1:0]       layer_k_stride,
    input  logic [4*CNT_W-1:0]       layer_num_words,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W+IDX_W-1:0]  mem_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+IDX_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     stream_filter_finish
);

    localparam int WORD_W = DATA_W + IDX_W;
    localparam int PROD_W = ADDR_W + K_W + CNT_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q;
    logic [LAYER_W-1:0]  layer_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    issued_q;
    logic [CNT_W-1:0]    rcvd_q;
    logic                inflight_q;

    logic [WORD_W-1:0]   fifo_mem [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fifo_cnt_q;

    logic [ADDR_W-1:0]   lyr_base;
    logic [CNT_W-1:0]    lyr_stride, lyr_num;
    logic [PROD_W-1:0]   base_wide;
    logic                abort, flush, ret_vld, keep_word, push, pop, rd_go;
    logic                head_vld, head_last, all_rcvd;
    logic [2:0]          occ;

    // Per-layer configuration for the captured layer and the group's start address (wraps mod 2^ADDR_W)
    always_comb begin
        lyr_base   = layer_base_addr[int'(layer_q)*ADDR_W +: ADDR_W];
        lyr_stride = layer_k_stride[int'(layer_q)*CNT_W +: CNT_W];
        lyr_num    = layer_num_words[int'(layer_q)*CNT_W +: CNT_W];
        base_wide  = PROD_W'(lyr_base) + PROD_W'(k_q) * PROD_W'(lyr_stride);
    end

    // Dropping the request mid-group flushes everything, including a read still in flight
    always_comb begin
        abort   = !req_filter_valid &&
                  ((state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_DRAIN));
        flush   = abort || (state_q == S_IDLE);
        ret_vld = inflight_q && !flush;
`ifdef FILTER_STREAM_ZERO_SKIP_EN
        keep_word = (mem_rd_data[WORD_W-1 -: DATA_W] != '0);
`else
        keep_word = 1'b1;
`endif
        push = ret_vld && keep_word;
    end

    // Head presentation: with zero skipping a lone head waits until we know whether it is the last one
    always_comb begin
        all_rcvd  = (rcvd_q == remaining_q);
        head_last = (fifo_cnt_q == 2'd1) && all_rcvd;
`ifdef FILTER_STREAM_ZERO_SKIP_EN
        head_vld  = req_filter_valid && ((fifo_cnt_q == 2'd2) || head_last);
`else
        head_vld  = req_filter_valid && (fifo_cnt_q != 2'd0);
`endif
    end

    assign pop = head_vld && out_ready;

    // Issue a read only if the FIFO, net of this cycle's pop, still has room for it and the word in flight
    always_comb begin
        occ   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_go = (state_q == S_STREAM) && req_filter_valid &&
                (issued_q != remaining_q) && (occ < 3'd2);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_filter_valid) state_d = S_LOAD;
            S_LOAD:   if (!req_filter_valid) state_d = S_IDLE;
                      else if (lyr_num == '0) state_d = S_DONE;
                      else state_d = S_STREAM;
            S_STREAM: if (!req_filter_valid) state_d = S_IDLE;
                      else if (rd_go && ((issued_q + CNT_W'(1)) == remaining_q)) state_d = S_DRAIN;
            S_DRAIN:  if (!req_filter_valid) state_d = S_IDLE;
                      else if (!inflight_q && (fifo_cnt_q == 2'd0)) state_d = S_DONE;
            S_DONE:   if (!req_filter_valid) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd_en            = rd_go;
        mem_rd_addr          = rd_go ? (base_q + ADDR_W'(issued_q)) : '0;
        out_valid            = head_vld;
        out_data             = head_vld ? fifo_mem[rd_ptr_q] : '0;
        out_last             = head_vld && head_last;
        stream_filter_finish = (state_q == S_DONE);
    end

    // Request capture, group setup and issue/return counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            layer_q     <= '0;
            base_q      <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            rcvd_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= rd_go;
            if ((state_q == S_IDLE) && req_filter_valid) begin
                k_q     <= req_filter_k;
                layer_q <= req_conv_layer;
            end
            if (state_q == S_LOAD) begin
                base_q      <= base_wide[ADDR_W-1:0];
                remaining_q <= lyr_num;
            end
            if (flush) begin
                issued_q <= '0;
                rcvd_q   <= '0;
            end else begin
                if (rd_go)   issued_q <= issued_q + CNT_W'(1);
                if (ret_vld) rcvd_q   <= rcvd_q + CNT_W'(1);
            end
        end
    end

    // Two-entry skid FIFO fed by returning read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= mem_rd_data;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_filter_stream_engine.sv
// Directed bench for filter_stream_engine: SRAM model with 1-cycle read latency,
// per-scenario tasks with hand-computed expectations.
module tb_filter_stream_engine;

    localparam int DATA_W = 16, IDX_W = 8, ADDR_W = 12, LAYER_W = 2, K_W = 6, CNT_W = 10;
    localparam int WORD_W = DATA_W + IDX_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_filter_valid;
    logic [K_W-1:0]      req_filter_k;
    logic [LAYER_W-1:0]  req_conv_layer;
    logic [4*ADDR_W-1:0] layer_base_addr;
    logic [4*CNT_W-1:0]  layer_k_stride;
    logic [4*CNT_W-1:0]  layer_num_words;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [WORD_W-1:0]   mem_rd_data = '0;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic                out_last;
    logic                stream_filter_finish;

    int total = 0;
    int bad   = 0;

    logic [WORD_W-1:0] mem_arr [4096];

    int                rd_addr_q[$];
    int                rd_cyc_q[$];
    logic [WORD_W-1:0] x_dat_q[$];
    bit                x_last_q[$];
    int                x_cyc_q[$];
    int                fin_cyc, n_ov, n_unstable;
    bit                timed_out;
    int                i_rd, i_ov, i_fin0, i_fin_later;

    always #5 clk = ~clk;

    filter_stream_engine dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_filter_valid    (req_filter_valid),
        .req_filter_k        (req_filter_k),
        .req_conv_layer      (req_conv_layer),
        .layer_base_addr     (layer_base_addr),
        .layer_k_stride      (layer_k_stride),
        .layer_num_words     (layer_num_words),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .stream_filter_finish(stream_filter_finish)
    );

    // Weight SRAM: data appears one cycle after the read enable
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_arr[mem_rd_addr];

    // Drive one request and record reads/transfers; rmode 1 stalls out_ready with pattern 1,0,0,1
    task automatic run_group(input int k, input int layer, input int rmode, input int drop_after, input int hold);
        bit prev_stall;
        logic [WORD_W-1:0] prev_data;
        rd_addr_q.delete(); rd_cyc_q.delete(); x_dat_q.delete(); x_last_q.delete(); x_cyc_q.delete();
        fin_cyc = -1; n_ov = 0; n_unstable = 0; timed_out = 1'b1; prev_stall = 1'b0; prev_data = '0;
        req_filter_k = K_W'(k); req_conv_layer = LAYER_W'(layer); req_filter_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            out_ready = (rmode == 0) ? 1'b1 : (((c % 4) == 1 || (c % 4) == 2) ? 1'b0 : 1'b1);
            @(negedge clk);
            if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_rd_addr)); rd_cyc_q.push_back(c); end
            if (prev_stall && (!out_valid || out_data !== prev_data)) n_unstable++;
            if (out_valid) n_ov++;
            if (out_valid && out_ready) begin
                x_dat_q.push_back(out_data); x_last_q.push_back(out_last); x_cyc_q.push_back(c);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (stream_filter_finish && fin_cyc < 0) fin_cyc = c;
            @(posedge clk); #1;
            if ((fin_cyc >= 0 && c >= fin_cyc + hold) || (drop_after >= 0 && x_dat_q.size() == drop_after)) begin
                req_filter_valid = 1'b0; out_ready = 1'b1; timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) req_filter_valid = 1'b0;
    endtask

    // Run cycles with no request and count any activity
    task automatic idle_cycles(input int n);
        i_rd = 0; i_ov = 0; i_fin0 = 0; i_fin_later = 0;
        out_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (mem_rd_en) i_rd++;
            if (out_valid) i_ov++;
            if (stream_filter_finish) begin if (c == 0) i_fin0++; else i_fin_later++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %0b want 0", mem_rd_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (stream_filter_finish !== 1'b0) begin bad++; $display("FAIL reset_finish: got %0b want 0", stream_filter_finish); end
        total++; if ({mem_rd_addr, out_last, out_data} !== '0) begin bad++; $display("FAIL reset_addr_last_data: got %0h want 0", {mem_rd_addr, out_last, out_data}); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({mem_rd_en, out_valid, stream_filter_finish} !== 3'b000) begin bad++; $display("FAIL post_reset_idle: got %b want 000", {mem_rd_en, out_valid, stream_filter_finish}); end
    endtask

    task automatic test_basic();
        run_group(2, 0, 0, -1, 1);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout: got no finish want finish"); end
        total++; if (rd_addr_q.size() != 5) begin bad++; $display("FAIL basic_rd_count: got %0d want 5", rd_addr_q.size()); end
        total++; if (rd_cyc_q[0] != 2) begin bad++; $display("FAIL basic_first_rd_cycle: got %0d want 2", rd_cyc_q[0]); end
        total++; if (rd_cyc_q[4] - rd_cyc_q[0] != 4) begin bad++; $display("FAIL basic_rd_back_to_back: got span %0d want 4", rd_cyc_q[4] - rd_cyc_q[0]); end
        for (int i = 0; i < 5; i++) begin
            total++; if (rd_addr_q[i] != 'h110 + i) begin bad++; $display("FAIL basic_addr%0d: got %0h want %0h", i, rd_addr_q[i], 'h110 + i); end
        end
        total++; if (x_dat_q.size() != 5) begin bad++; $display("FAIL basic_xfer_count: got %0d want 5", x_dat_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++; if (x_dat_q[i] !== mem_arr['h110 + i]) begin bad++; $display("FAIL basic_data%0d: got %0h want %0h", i, x_dat_q[i], mem_arr['h110 + i]); end
            total++; if (x_last_q[i] != (i == 4)) begin bad++; $display("FAIL basic_last%0d: got %0b want %0b", i, x_last_q[i], (i == 4)); end
        end
`ifndef FILTER_STREAM_ZERO_SKIP_EN
        // Transfers run cycles 4..8, DRAIN sees the FIFO empty in cycle 9, finish in cycle 10
        total++; if (x_cyc_q[4] - x_cyc_q[0] != 4) begin bad++; $display("FAIL basic_sustained: got span %0d want 4", x_cyc_q[4] - x_cyc_q[0]); end
        total++; if (fin_cyc != 10) begin bad++; $display("FAIL basic_finish_cycle: got %0d want 10", fin_cyc); end
`endif
        idle_cycles(3);
        total++; if (i_fin0 != 1) begin bad++; $display("FAIL basic_finish_level: got %0d want 1", i_fin0); end
        total++; if (i_fin_later != 0) begin bad++; $display("FAIL basic_finish_drop: got %0d want 0", i_fin_later); end
        total++; if (i_rd + i_ov != 0) begin bad++; $display("FAIL basic_idle_quiet: got %0d want 0", i_rd + i_ov); end
    endtask

    task automatic test_stall();
        run_group(2, 0, 1, -1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL stall_timeout: got no finish want finish"); end
        total++; if (rd_addr_q.size() != 5) begin bad++; $display("FAIL stall_rd_count: got %0d want 5", rd_addr_q.size()); end
        total++; if (x_dat_q.size() != 5) begin bad++; $display("FAIL stall_xfer_count: got %0d want 5", x_dat_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++; if (x_dat_q[i] !== mem_arr['h110 + i]) begin bad++; $display("FAIL stall_data%0d: got %0h want %0h", i, x_dat_q[i], mem_arr['h110 + i]); end
        end
        total++; if (x_last_q[4] != 1'b1 || x_last_q[3] != 1'b0) begin bad++; $display("FAIL stall_last: got %0b%0b want 10", x_last_q[4], x_last_q[3]); end
        total++; if (n_unstable != 0) begin bad++; $display("FAIL stall_hold_stable: got %0d changes want 0", n_unstable); end
        idle_cycles(2);
    endtask

    task automatic test_abort();
        run_group(2, 0, 0, 2, 0);
        total++; if (timed_out) begin bad++; $display("FAIL abort_timeout: got no drop want drop"); end
        total++; if (fin_cyc != -1) begin bad++; $display("FAIL abort_no_finish_early: got %0d want -1", fin_cyc); end
        idle_cycles(4);
        total++; if (i_fin0 + i_fin_later != 0) begin bad++; $display("FAIL abort_finish: got %0d want 0", i_fin0 + i_fin_later); end
        total++; if (i_ov != 0) begin bad++; $display("FAIL abort_out_valid: got %0d want 0", i_ov); end
        total++; if (i_rd != 0) begin bad++; $display("FAIL abort_rd: got %0d want 0", i_rd); end
        run_group(2, 0, 0, -1, 0);
        total++; if (rd_addr_q[0] != 'h110) begin bad++; $display("FAIL abort_restart_addr: got %0h want 110", rd_addr_q[0]); end
        total++; if (x_dat_q.size() != 5) begin bad++; $display("FAIL abort_restart_count: got %0d want 5", x_dat_q.size()); end
        total++; if (x_dat_q[0] !== mem_arr['h110]) begin bad++; $display("FAIL abort_restart_data: got %0h want %0h", x_dat_q[0], mem_arr['h110]); end
        total++; if (timed_out) begin bad++; $display("FAIL abort_restart_finish: got no finish want finish"); end
        idle_cycles(2);
    endtask

    task automatic test_zero_group();
        run_group(5, 3, 0, -1, 0);
        total++; if (fin_cyc != 2) begin bad++; $display("FAIL zero_finish_cycle: got %0d want 2", fin_cyc); end
        total++; if (rd_addr_q.size() != 0) begin bad++; $display("FAIL zero_rd_count: got %0d want 0", rd_addr_q.size()); end
        total++; if (n_ov != 0) begin bad++; $display("FAIL zero_out_valid: got %0d want 0", n_ov); end
        idle_cycles(2);
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{'hFFE, 'hFFF, 'h000, 'h001};
        run_group(0, 2, 0, -1, 0);
        total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL wrap_rd_count: got %0d want 4", rd_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_addr_q[i] != exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d: got %0h want %0h", i, rd_addr_q[i], exp_a[i]); end
            total++; if (x_dat_q[i] !== mem_arr[exp_a[i]]) begin bad++; $display("FAIL wrap_data%0d: got %0h want %0h", i, x_dat_q[i], mem_arr[exp_a[i]]); end
        end
        total++; if (x_last_q[3] != 1'b1) begin bad++; $display("FAIL wrap_last: got %0b want 1", x_last_q[3]); end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; req_filter_k = 6'd3; req_conv_layer = 2'd1; req_filter_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin @(negedge clk); @(posedge clk); #1; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_streaming: got %0b want 1", out_valid); end
        rst = 1'b1; #1;
        total++; if ({mem_rd_en, mem_rd_addr, out_valid, out_last, out_data, stream_filter_finish} !== '0) begin
            bad++; $display("FAIL rstmid_outputs_zero: got %0h want 0", {mem_rd_en, mem_rd_addr, out_valid, out_last, out_data, stream_filter_finish});
        end
        req_filter_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        // 0xFF0 + 3*7 = 0x1005 wraps to 0x005
        run_group(3, 1, 0, -1, 0);
        total++; if (rd_addr_q.size() != 3 || rd_addr_q[0] != 'h005 || rd_addr_q[2] != 'h007) begin bad++; $display("FAIL rstmid_addrs: got n=%0d first=%0h want n=3 first=5", rd_addr_q.size(), rd_addr_q[0]); end
        total++; if (x_dat_q.size() != 3) begin bad++; $display("FAIL rstmid_count: got %0d want 3", x_dat_q.size()); end
        total++; if (x_dat_q[2] !== mem_arr['h007] || x_last_q[2] != 1'b1) begin bad++; $display("FAIL rstmid_last_word: got %0h/%0b want %0h/1", x_dat_q[2], x_last_q[2], mem_arr['h007]); end
        idle_cycles(2);
    endtask

    task automatic test_zero_words();
        layer_num_words[4*CNT_W-1 -: CNT_W] = 10'd4;
        run_group(0, 3, 0, -1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL zw_finish: got no finish want finish"); end
`ifdef FILTER_STREAM_ZERO_SKIP_EN
        total++; if (x_dat_q.size() != 2) begin bad++; $display("FAIL zw_count: got %0d want 2", x_dat_q.size()); end
        total++; if (x_dat_q[0] !== 24'h000311) begin bad++; $display("FAIL zw_first: got %0h want 000311", x_dat_q[0]); end
        total++; if (x_dat_q[1] !== 24'h000733) begin bad++; $display("FAIL zw_second: got %0h want 000733", x_dat_q[1]); end
        total++; if (x_last_q[0] != 1'b0 || x_last_q[1] != 1'b1) begin bad++; $display("FAIL zw_last: got %0b%0b want 01", x_last_q[0], x_last_q[1]); end
        idle_cycles(2);
        run_group(1, 3, 0, -1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL zw_allzero_finish: got no finish want finish"); end
        total++; if (n_ov != 0) begin bad++; $display("FAIL zw_allzero_valid: got %0d want 0", n_ov); end
        total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL zw_allzero_rd: got %0d want 4", rd_addr_q.size()); end
`else
        total++; if (x_dat_q.size() != 4) begin bad++; $display("FAIL zw_count: got %0d want 4", x_dat_q.size()); end
        total++; if (x_dat_q[1] !== 24'h000022) begin bad++; $display("FAIL zw_zero_kept: got %0h want 000022", x_dat_q[1]); end
        total++; if (x_dat_q[2] !== 24'h000733) begin bad++; $display("FAIL zw_third: got %0h want 000733", x_dat_q[2]); end
        total++; if (x_last_q[3] != 1'b1 || x_last_q[2] != 1'b0) begin bad++; $display("FAIL zw_last: got %0b%0b want 10", x_last_q[3], x_last_q[2]); end
`endif
        idle_cycles(2);
    endtask

    initial begin
        rst = 1'b1; req_filter_valid = 1'b0; req_filter_k = '0; req_conv_layer = '0; out_ready = 1'b1;
        layer_base_addr = {12'h300, 12'hFFE, 12'hFF0, 12'h100};
        layer_k_stride  = {10'd4, 10'd1, 10'd7, 10'd8};
        layer_num_words = {10'd0, 10'd4, 10'd3, 10'd5};
        for (int a = 0; a < 4096; a++) mem_arr[a] = {16'(16'h1000 + a), 8'(a)};
        mem_arr['h300] = 24'h000311; mem_arr['h301] = 24'h000022;
        mem_arr['h302] = 24'h000733; mem_arr['h303] = 24'h000044;
        for (int a = 'h304; a < 'h308; a++) mem_arr[a] = {16'h0000, 8'(a)};
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_zero_group();
        test_wrap();
        test_reset_mid();
        test_zero_words();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
